wb_dma_addr_gen: RTL and testbench

//  Parametrised DMA address generator; successor to the fixed 30-bit +1 incrementer.

---
 rtl/wb_dma_addr_gen_pkg.sv | 30 +++
 rtl/wb_dma_addr_gen_if.sv | 33 +++
 rtl/wb_dma_addr_gen_step.sv | 37 +++
 rtl/wb_dma_addr_gen.sv | 104 ++++++++++
 tb/tb_wb_dma_addr_gen.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_dma_addr_gen_pkg.sv
// Shared types for the DMA address generator: addressing modes, FSM states and
// the mode-code decoder used at load time.
package wb_dma_addr_pkg;

  localparam int AGEN_AW = 30;
  localparam int AGEN_SW = 4;
  localparam int AGEN_CW = 12;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_WRAP = 2'd2
  } addr_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } agen_state_t;

  // The reserved code 3 folds onto HOLD so an unprogrammed channel never walks memory.
  function automatic addr_mode_t decode_mode(input logic [1:0] code);
    case (code)
      2'd0:    return MODE_INC;
      2'd2:    return MODE_WRAP;
      default: return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/wb_dma_addr_gen_if.sv
// Load/advance/status bundle between the channel register file (master) and
// the address generator (slave).
interface wb_dma_addr_gen_if #(
  parameter int AW = 30,
  parameter int SW = 4,
  parameter int CW = 12
);

  logic          ld;
  logic [AW-1:0] ld_addr;
  logic [CW-1:0] ld_cnt;
  logic [SW-1:0] ld_stride;
  logic [1:0]    ld_mode;
  logic [AW-1:0] ld_mask;
  logic          adv;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;
  logic          ovf;

  modport master (
    output ld, ld_addr, ld_cnt, ld_stride, ld_mode, ld_mask, adv,
    input  addr, addr_nxt, cnt, busy, done, ovf
  );

  modport slave (
    input  ld, ld_addr, ld_cnt, ld_stride, ld_mode, ld_mask, adv,
    output addr, addr_nxt, cnt, busy, done, ovf
  );

endinterface

// File: rtl/wb_dma_addr_gen_step.sv
// Combinational address step: one beat's worth of INC, HOLD or WRAP advance.
// Kept separate so a per-channel wrapper can reuse it.
module wb_dma_addr_step
  import wb_dma_addr_pkg::*;
#(
  parameter int AW = AGEN_AW,
  parameter int SW = AGEN_SW
) (
  input  logic [AW-1:0] addr_i,
  input  logic [SW-1:0] stride_i,
  input  addr_mode_t    mode_i,
  input  logic [AW-1:0] mask_i,
  output logic [AW-1:0] addr_nxt_o,
  output logic          carry_o
);

  logic [AW:0] sum;

  assign sum = {1'b0, addr_i} + (AW+1)'(stride_i);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    addr_nxt_o = addr_i;
    carry_o    = 1'b0;
    case (mode_i)
      MODE_INC: begin
        addr_nxt_o = sum[AW-1:0];
        carry_o    = sum[AW];
      end
      // Only the masked window moves; carries out of it are discarded.
      MODE_WRAP: addr_nxt_o = (addr_i & ~mask_i) | (sum[AW-1:0] & mask_i);
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_dma_addr_gen.sv
// DMA address generator: holds the transfer address, remaining beat count and
// stride configuration, and flags completion and INC overflow.
module wb_dma_addr_gen
  import wb_dma_addr_pkg::*;
#(
  parameter int AW = AGEN_AW,
  parameter int SW = AGEN_SW,
  parameter int CW = AGEN_CW
) (
  input  logic              clk,
  input  logic              rst,
  wb_dma_addr_gen_if.slave  bus
);

  agen_state_t   state_q;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] stride_q;
  addr_mode_t    mode_q;
  logic [AW-1:0] mask_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] addr_d;
  logic          carry_d;

  wb_dma_addr_step #(
    .AW(AW),
    .SW(SW)
  ) u_step (
    .addr_i     (addr_q),
    .stride_i   (stride_q),
    .mode_i     (mode_q),
    .mask_i     (mask_q),
    .addr_nxt_o (addr_d),
    .carry_o    (carry_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      stride_q <= '0;
      mode_q   <= MODE_HOLD;
      mask_q   <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.ld) begin
      // A load aborts any transfer in flight and starts the new one cleanly.
      addr_q   <= bus.ld_addr;
      cnt_q    <= bus.ld_cnt;
      stride_q <= bus.ld_stride;
      mode_q   <= decode_mode(bus.ld_mode);
      mask_q   <= bus.ld_mask;
      ovf_q    <= 1'b0;
      if (bus.ld_cnt != '0) begin
        state_q <= S_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        state_q <= S_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.adv) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_q - CW'(1);
            if (carry_d) ovf_q <= 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr     = addr_q;
  assign bus.addr_nxt = addr_d;
  assign bus.cnt      = cnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_wb_dma_addr_gen.sv
// Directed scenarios plus a random ld/adv/rst soak against a behavioural model
// of the address generator.
module tb_wb_dma_addr_gen;

  localparam int AW = 30;
  localparam int SW = 4;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  wb_dma_addr_gen_if #(.AW(AW), .SW(SW), .CW(CW)) bus ();

  wb_dma_addr_gen #(.AW(AW), .SW(SW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: the transfer as a whole, not the FSM encoding.
  logic [AW-1:0] m_addr   = '0;
  int            m_cnt    = 0;
  logic [SW-1:0] m_stride = '0;
  logic [1:0]    m_mode   = 2'd1;
  logic [AW-1:0] m_mask   = '0;
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  bit            m_ovf    = 1'b0;

  function automatic logic [AW-1:0] ref_next(input logic [AW-1:0] a, input logic [SW-1:0] s,
                                             input logic [1:0] mode, input logic [AW-1:0] mask,
                                             output bit carry);
    longint unsigned sum = longint'(a) + longint'(s);
    longint unsigned lim = 64'd1 << AW;
    carry = 1'b0;
    case (mode)
      2'd0: begin
        carry = (sum >= lim);
        return AW'(sum % lim);
      end
      2'd2: return (a & ~mask) | (AW'(sum) & mask);
      default: return a;
    endcase
  endfunction

  task automatic model_update();
    bit c;
    if (rst) begin
      m_addr = '0; m_cnt = 0; m_stride = '0; m_mode = 2'd1; m_mask = '0;
      m_active = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    end else if (bus.ld) begin
      m_addr = bus.ld_addr; m_cnt = int'(bus.ld_cnt); m_stride = bus.ld_stride;
      m_mode = bus.ld_mode; m_mask = bus.ld_mask; m_ovf = 1'b0;
      m_active = (bus.ld_cnt != 0);
      m_done   = (bus.ld_cnt == 0);
    end else begin
      m_done = 1'b0;
      if (m_active && bus.adv) begin
        m_addr = ref_next(m_addr, m_stride, m_mode, m_mask, c);
        if (c) m_ovf = 1'b1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [CW-1:0] c, input logic [SW-1:0] s,
                      input logic [1:0] mode, input logic [AW-1:0] mask);
    bus.ld_addr = a; bus.ld_cnt = c; bus.ld_stride = s; bus.ld_mode = mode; bus.ld_mask = mask;
    bus.ld = 1'b1; bus.adv = 1'b0;
    tick();
    bus.ld = 1'b0;
  endtask

  task automatic adv_beat();
    bus.adv = 1'b1;
    tick();
    bus.adv = 1'b0;
  endtask

  property p_adv_addr;
    @(posedge clk) disable iff (rst) (bus.busy && bus.adv && !bus.ld) |=> (bus.addr == $past(bus.addr_nxt));
  endproperty
  a_adv_addr: assert property (p_adv_addr)
    else begin
      n_err++;
      $display("FAIL adv_addr_past: addr=%h does not match addr_nxt of the previous cycle", bus.addr);
    end

  task automatic test_reset();
    rst = 1'b1; bus.ld = 1'b1; bus.ld_addr = 30'h123; bus.ld_cnt = 12'd5; bus.adv = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.addr, bus.addr_nxt, bus.cnt, bus.busy, bus.done, bus.ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_state: addr=%h nxt=%h cnt=%0d busy=%b done=%b ovf=%b expected all zero",
               bus.addr, bus.addr_nxt, bus.cnt, bus.busy, bus.done, bus.ovf);
    end
    rst = 1'b0; bus.ld = 1'b0; bus.adv = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_inc();
    load(30'h100, 12'd3, 4'd1, 2'd0, '0);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.addr !== 30'h100 || bus.cnt !== 12'd3 || bus.addr_nxt !== 30'h101) begin
      n_err++;
      $display("FAIL inc_load: busy=%b addr=%h cnt=%0d nxt=%h expected 1 100 3 101",
               bus.busy, bus.addr, bus.cnt, bus.addr_nxt);
    end
    for (int i = 1; i <= 3; i++) begin
      adv_beat();
      n_cmp++;
      if (bus.addr !== AW'(32'h100 + i) || bus.cnt !== CW'(3 - i) ||
          bus.done !== (i == 3) || bus.busy !== (i != 3)) begin
        n_err++;
        $display("FAIL inc_beat%0d: addr=%h cnt=%0d done=%b busy=%b expected %h %0d %b %b", i,
                 bus.addr, bus.cnt, bus.done, bus.busy, 32'h100 + i, 3 - i, i == 3, i != 3);
      end
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL inc_done_pulse: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_inc_overflow();
    load(30'h3FFFFFFE, 12'd4, 4'd2, 2'd0, '0);
    adv_beat();
    n_cmp++;
    if (bus.addr !== 30'h0 || bus.ovf !== 1'b1 || bus.cnt !== 12'd3) begin
      n_err++;
      $display("FAIL ovf_beat1: addr=%h ovf=%b cnt=%0d expected 0 1 3", bus.addr, bus.ovf, bus.cnt);
    end
    adv_beat();
    tick();
    n_cmp++;
    if (bus.addr !== 30'h2 || bus.ovf !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: addr=%h ovf=%b busy=%b expected 2 1 1", bus.addr, bus.ovf, bus.busy);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 30'h1FC; exp_a[1] = 30'h1F0; exp_a[2] = 30'h1F4; exp_a[3] = 30'h1F8;
    load(30'h1F8, 12'd4, 4'd4, 2'd2, 30'h00F);
    n_cmp++;
    if (bus.ovf !== 1'b0 || bus.addr_nxt !== 30'h1FC) begin
      n_err++;
      $display("FAIL wrap_load: ovf=%b nxt=%h expected 0 1fc", bus.ovf, bus.addr_nxt);
    end
    for (int i = 0; i < 4; i++) begin
      adv_beat();
      n_cmp++;
      if (bus.addr !== exp_a[i] || bus.ovf !== 1'b0 || bus.done !== (i == 3)) begin
        n_err++;
        $display("FAIL wrap_beat%0d: addr=%h ovf=%b done=%b expected %h 0 %b", i,
                 bus.addr, bus.ovf, bus.done, exp_a[i], i == 3);
      end
    end
  endtask

  task automatic test_empty();
    tick(); tick();
    load(30'h55, 12'd0, 4'd3, 2'd0, '0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cnt !== 12'd0) begin
      n_err++;
      $display("FAIL empty_done: done=%b busy=%b cnt=%0d expected 1 0 0", bus.done, bus.busy, bus.cnt);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL empty_after: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    adv_beat();
    n_cmp++;
    if (bus.addr !== 30'h55 || bus.cnt !== 12'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_adv: addr=%h cnt=%0d busy=%b done=%b expected 55 0 0 0",
               bus.addr, bus.cnt, bus.busy, bus.done);
    end
  endtask

  task automatic test_ld_priority();
    load(30'h10, 12'd5, 4'd1, 2'd0, '0);
    adv_beat();
    bus.ld_addr = 30'h200; bus.ld_cnt = 12'd7; bus.ld_stride = 4'd1; bus.ld_mode = 2'd0;
    bus.ld = 1'b1; bus.adv = 1'b1;
    tick();
    bus.ld = 1'b0; bus.adv = 1'b0;
    n_cmp++;
    if (bus.addr !== 30'h200 || bus.cnt !== 12'd7 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL ld_over_adv: addr=%h cnt=%0d busy=%b done=%b expected 200 7 1 0",
               bus.addr, bus.cnt, bus.busy, bus.done);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.cnt !== 12'd7) begin
      n_err++;
      $display("FAIL abort_no_done: done=%b cnt=%0d expected 0 7", bus.done, bus.cnt);
    end
  endtask

  task automatic test_reset_midrun();
    load(30'h3FFFFFFF, 12'd5, 4'd3, 2'd0, '0);
    adv_beat();
    n_cmp++;
    if (bus.addr !== 30'h2 || bus.ovf !== 1'b1 || bus.cnt !== 12'd4) begin
      n_err++;
      $display("FAIL rst_pre: addr=%h ovf=%b cnt=%0d expected 2 1 4", bus.addr, bus.ovf, bus.cnt);
    end
    rst = 1'b1; bus.ld = 1'b1; bus.ld_addr = 30'h999; bus.ld_cnt = 12'd2; bus.adv = 1'b1;
    tick();
    rst = 1'b0; bus.ld = 1'b0; bus.adv = 1'b0;
    n_cmp++;
    if ({bus.addr, bus.addr_nxt, bus.cnt, bus.busy, bus.done, bus.ovf} !== '0) begin
      n_err++;
      $display("FAIL rst_midrun: addr=%h nxt=%h cnt=%0d busy=%b done=%b ovf=%b expected all zero",
               bus.addr, bus.addr_nxt, bus.cnt, bus.busy, bus.done, bus.ovf);
    end
  endtask

  task automatic test_random_soak();
    logic [AW-1:0] e_nxt;
    bit            c;
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(63) == 0);
      bus.ld = ($urandom_range(7) == 0);
      bus.adv = 1'($urandom_range(1));
      if (bus.ld) begin
        bus.ld_addr   = ($urandom_range(3) == 0) ? ({AW{1'b1}} - AW'($urandom_range(8))) : AW'($urandom);
        bus.ld_cnt    = CW'($urandom_range(1, 12));
        bus.ld_stride = SW'($urandom);
        bus.ld_mode   = 2'($urandom);
        bus.ld_mask   = AW'($urandom);
      end
      tick();
      e_nxt = ref_next(m_addr, m_stride, m_mode, m_mask, c);
      n_cmp++;
      if (bus.addr !== m_addr || bus.addr_nxt !== e_nxt || bus.cnt !== CW'(m_cnt) ||
          bus.busy !== m_active || bus.done !== m_done || bus.ovf !== m_ovf) begin
        n_err++;
        $display("FAIL soak%0d: got addr=%h nxt=%h cnt=%0d busy=%b done=%b ovf=%b expected %h %h %0d %b %b %b",
                 i, bus.addr, bus.addr_nxt, bus.cnt, bus.busy, bus.done, bus.ovf,
                 m_addr, e_nxt, m_cnt, m_active, m_done, m_ovf);
      end
    end
    rst = 1'b0; bus.ld = 1'b0; bus.adv = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ld = 1'b0; bus.adv = 1'b0; bus.ld_addr = '0; bus.ld_cnt = '0;
    bus.ld_stride = '0; bus.ld_mode = 2'd0; bus.ld_mask = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_inc();
    test_inc_overflow();
    test_wrap();
    test_empty();
    test_ld_priority();
    test_reset_midrun();
    test_random_soak();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
